md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer with HI/LO registers for the 5-stage MIPS pipeline.
//  Accepts an MDU op issued from the E stage and computes the result at issue.
//  Holds that result for a fixed per-op latency, then commits it to HI/LO.
//  Drives the stall used by the hazard unit so that md-type instructions in D wait while the unit is busy.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy after MULT/MULTU issue (>=1)
//  DIV_CYCLES   10  cycles busy after DIV/DIVU issue (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  start     in   1   E-stage instr is an md op, qualified (no E flush)
//  md_op     in   3   MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO
//  rs_val    in   32  forwarded rs operand (E)
//  rt_val    in   32  forwarded rt operand (E)
//  md_use_D  in   1   D-stage instr reads or writes HI/LO or is an md op
//  busy      out  1   operation in flight
//  stall     out  1   md_use_D & (busy | start-of-mult/div)
//  hi        out  32  HI register (read by MFHI in E)
//  lo        out  32  LO register (read by MFLO in E)
// BEHAVIOUR
//  Reset: cnt=0, busy=0, hi=0, lo=0, pend_hi=pend_lo=0. A reset mid-operation abandons it; HI/LO are not written.
//  States: IDLE (cnt==0), RUN (cnt!=0); busy = (cnt!=0), registered.
//  IDLE & start & mult/div:
//   - latch pending result into pend_hi/pend_lo.
//   - cnt <= MULT_CYCLES or DIV_CYCLES; this goes to RUN.
//  RUN: cnt decrements each cycle. On the edge where cnt goes 1->0: hi<=pend_hi, lo<=pend_lo.
//   - busy is high for exactly N cycles after the issue edge.
//   - New HI/LO become visible on the same edge that busy falls.
//  MTHI/MTLO in IDLE: hi (or lo) <= rs_val at the issue edge; 1-cycle effect, busy stays 0.
//  start while busy: ignored (pending result, cnt and HI/LO unchanged). Hazard unit prevents this.
//  MULT: {hi,lo} = signed 64-bit rs*rt.  MULTU: unsigned.
//  DIV:  lo = rs/rt, hi = rs%rt, both signed, truncating toward zero. Remainder takes the sign of the dividend.
//  DIVU: unsigned quotient/remainder.
//  Divide by zero (rt==0), DIV or DIVU: lo=32'hFFFFFFFF, hi=rs_val. This is the defined result; there is no exception.
//  DIV 32'h80000000 / -1: lo=32'h80000000, hi=0.
//  stall = md_use_D & (busy | (start & md_op is mult/div)). Combinational from registered busy and E-stage inputs.
//  hi/lo are pure registers; no bypass of pending values.
//  Undefined md_op encodings: treated as no-op.
// STRUCTURE
//  MD_* opcode encodings (3-bit) are defined in shared header.v, alongside the existing ctrl decode constants.
//  ctrl decode generates start/md_op/md_use_D; this block does not decode IR.
//  One sub-module: md_alu. It is combinational, (md_op, rs_val, rt_val) -> {res_hi,res_lo}, and holds the signed/unsigned
//   multiply and divide, including the divide-by-zero and overflow cases.
//  md_ctrl holds the counter, pending registers, HI/LO and the stall.
//  Target size: 150-250 lines total.
// TESTING
//  1 MULT rs=3 rt=32'hFFFFFFFE at t0
//     -> busy=1 for t1..t5; at t5 edge hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, busy=0.
//  2 DIVU rs=7 rt=2
//     -> busy 10 cycles, then lo=3, hi=1.
//    DIV rs=32'hFFFFFFF9 rt=2
//     -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
//  3 DIV rs=5 rt=0
//     -> lo=32'hFFFFFFFF, hi=5.
//    DIV rs=32'h80000000 rt=32'hFFFFFFFF
//     -> lo=32'h80000000, hi=0.
//  4 MULTU issued; reset asserted at cycle 3 of RUN
//     -> next edge busy=0, hi=lo=0; HI/LO remain 0 at cycles 5 and 6.
//  5 MTHI rs=32'h1234 in IDLE
//     -> hi=32'h1234 next edge, busy stays 0.
//    MTLO or MULT issued while busy
//     -> ignored; final HI/LO equal the first op's result.
//  6 md_use_D=1 with start of MULT
//     -> stall=1 that cycle and all 5 busy cycles, 0 after.
//    md_use_D=0 while busy
//     -> stall=0.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MD op encodings, the
// sequencer state type and small op-classification helpers.
package md_ctrl_pkg;

    // 3-bit MD op encodings produced by ctrl decode; 0 and 7 are no-ops.
    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // The sequencer is idle when its countdown is zero, running otherwise.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the multiply ops (selects the shorter latency).
    function automatic logic is_mult(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_ctrl_alu.sv
// Combinational MDU datapath: signed/unsigned multiply and divide producing
// the {hi, lo} pair, including the defined divide-by-zero and overflow cases.
module md_alu
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] safe_rt;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Full-width products; sign-extending to 64 bits keeps the low 64 bits exact.
    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // The special cases are resolved by muxing, so the divider never sees a
    // zero divisor or the MIN/-1 pair; substituting 1 keeps simulation clean.
    assign div_zero = (rt_val == 32'd0);
    assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign safe_rt  = (div_zero || div_ovf) ? 32'd1 : rt_val;

    // Verilog signed division truncates toward zero; remainder follows the dividend.
    assign quot_s = $signed(rs_val) / $signed(safe_rt);
    assign rem_s  = $signed(rs_val) % $signed(safe_rt);
    assign quot_u = rs_val / safe_rt;
    assign rem_u  = rs_val % safe_rt;

    // Select the result pair for the requested op.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    res_hi = rs_val;
                    res_lo = 32'hFFFF_FFFF;
                end else if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    res_hi = rs_val;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = rem_u;
                    res_lo = quot_u;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer with HI/LO registers. The result is computed at
// issue, held for a fixed per-op latency, then committed to HI/LO on the edge
// where busy falls. Also drives the D-stage stall for md-type instructions.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic [31:0]       pend_hi_reg;
    logic [31:0]       pend_lo_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    md_alu u_md_alu (
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Sequencer: issue in IDLE, count down in RUN, commit pending result on 1->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (is_muldiv(md_op)) begin
                            pend_hi_reg <= res_hi;
                            pend_lo_reg <= res_lo;
                            cnt_reg     <= is_mult(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy_reg    <= 1'b1;
                            state_reg   <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            hi_reg <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            lo_reg <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    // Any start while running is ignored; the hazard unit keeps it from happening.
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        hi_reg    <= pend_hi_reg;
                        lo_reg    <= pend_lo_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Stall D-stage md instructions while busy or while a mult/div is issuing in E.
    always_comb begin
        stall = md_use_D & (busy_reg | (start & is_muldiv(md_op)));
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, results, special divide cases,
// MTHI/MTLO, ignored issue while busy, reset mid-operation and stall.
module tb_md_ctrl;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_UND   = 3'd7;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div, measure busy length, stall behaviour and committed HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic use_d, input int exp_n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi_prev;
        int          n_busy;
        logic        stall_bad;
        hi_prev   = hi;
        n_busy    = 0;
        stall_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = rs; rt_val = rt; md_use_D = use_d;
        #1;
        check({tag, "_stall_issue"}, {31'd0, stall}, {31'd0, use_d});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_hi_held"}, hi, hi_prev);
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            n_busy++;
            if (stall !== use_d) stall_bad = 1'b1;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, n_busy, exp_n);
        check({tag, "_stall_busy"}, {31'd0, stall_bad}, 32'd0);
        check({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        md_use_D = 1'b0;
        $display("txn %s op=%0d rs=%h rt=%h -> busy %0d cycles hi=%h lo=%h", tag, op, rs, rt, n_busy, hi, lo);
    endtask

    initial begin
        int n_busy;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; md_op = OP_NOP; rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);

        // Multiply and divide results, with stall when a D-stage md op is waiting.
        do_op("mult_3_m2",     OP_MULT,  32'd3,          32'hFFFF_FFFE, 1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("divu_7_2",      OP_DIVU,  32'd7,          32'd2,         1'b0, 10, 32'd1,         32'd3);
        do_op("div_m7_2",      OP_DIV,   32'hFFFF_FFF9,  32'd2,         1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_7_m2",      OP_DIV,   32'd7,          32'hFFFF_FFFE, 1'b0, 10, 32'd1,         32'hFFFF_FFFD);
        do_op("div_5_0",       OP_DIV,   32'd5,          32'd0,         1'b0, 10, 32'd5,         32'hFFFF_FFFF);
        do_op("divu_9_0",      OP_DIVU,  32'd9,          32'd0,         1'b1, 10, 32'd9,         32'hFFFF_FFFF);
        do_op("div_min_m1",    OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 10, 32'd0,         32'h8000_0000);
        do_op("multu_max_max", OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 5,  32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_min_min",  OP_MULT,  32'h8000_0000,  32'h8000_0000, 1'b0, 5,  32'h4000_0000, 32'h0000_0000);

        // MTHI / MTLO in idle take effect on the issue edge without going busy.
        @(negedge clk);
        start = 1'b1; md_op = OP_MTHI; rs_val = 32'h0000_1234;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        $display("txn mthi rs=%h -> hi=%h busy=%b", 32'h0000_1234, hi, busy);
        start = 1'b1; md_op = OP_MTLO; rs_val = 32'h0000_5678;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h0000_5678);
        check("mtlo_hi_kept", hi, 32'h0000_1234);
        $display("txn mtlo rs=%h -> lo=%h busy=%b", 32'h0000_5678, lo, busy);

        // Undefined encoding is a no-op.
        start = 1'b1; md_op = OP_UND; rs_val = 32'hAAAA_AAAA; rt_val = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", hi, 32'h0000_1234);
        check("undef_lo", lo, 32'h0000_5678);
        $display("txn undefined op=7 -> hi=%h lo=%h busy=%b", hi, lo, busy);

        // Issue while busy is ignored: MULT 2*3, then MTLO and MULT 7*7 during RUN.
        start = 1'b1; md_op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ign_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; md_op = OP_MTLO; rs_val = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 md_op = OP_MULT; rs_val = 32'd7; rt_val = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ign_lo_held", lo, 32'h0000_5678);
        n_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            n_busy++;
            @(negedge clk);
        end
        check("ign_busy_rest", n_busy, 3);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd6);
        $display("txn mult 2*3 with mtlo/mult issued while busy -> hi=%h lo=%h", hi, lo);

        // Reset during RUN abandons the op: HI/LO cleared and never written.
        start = 1'b1; md_op = OP_MULTU; rs_val = 32'd4; rt_val = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_run_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_run_busy", {31'd0, busy}, 32'd0);
        check("rst_run_hi", hi, 32'd0);
        check("rst_run_lo", lo, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_run_hi_c5", hi, 32'd0);
        check("rst_run_lo_c5", lo, 32'd0);
        @(negedge clk);
        check("rst_run_hi_c6", hi, 32'd0);
        check("rst_run_lo_c6", lo, 32'd0);
        check("rst_run_busy_c6", {31'd0, busy}, 32'd0);
        $display("txn multu 4*5 reset mid-run -> hi=%h lo=%h busy=%b", hi, lo, busy);

        // Stall is only raised when a D-stage md op is present.
        md_use_D = 1'b1;
        #1;
        check("stall_idle_use", {31'd0, stall}, 32'd0);
        md_use_D = 1'b0;
        do_op("mult_after_rst", OP_MULT, 32'hFFFF_FFFF, 32'd5, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
